// File: rtl/main_memory_backend.sv
// main_memory_backend
//   Backing main memory behind the cache controller. Serves one request at a
//   time: a line fill (read) or a line write-back (write). Each access costs a
//   fixed LATENCY wait, and data moves as WORDS_PER_LINE beats starting at word 0.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   mem_req_valid/ready/we/line     request handshake: we=1 write-back, we=0 fill
//   mem_wdata/_valid/_ready         write beat stream (write-back data)
//   mem_rdata/_valid/_last/_ready   read beat stream (fill data)
//   mem_wr_done                     one-cycle pulse when a write-back is committed
module main_memory_backend #(
   parameter int    WORD_W         = 32,
   parameter int    WORDS_PER_LINE = 4,
   parameter int    MEM_WORDS      = 1024,
   parameter int    LATENCY        = 4,
   parameter string INIT_FILE      = "",
   localparam int   LINE_AW        = $clog2(MEM_WORDS / WORDS_PER_LINE),
   localparam int   BEAT_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_req_valid,
   output logic               mem_req_ready,
   input  logic               mem_req_we,
   input  logic [LINE_AW-1:0] mem_req_line,
   input  logic [WORD_W-1:0]  mem_wdata,
   input  logic               mem_wdata_valid,
   output logic               mem_wdata_ready,
   output logic [WORD_W-1:0]  mem_rdata,
   output logic               mem_rdata_valid,
   output logic               mem_rdata_last,
   input  logic               mem_rdata_ready,
   output logic               mem_wr_done
);

   localparam int LAT_W = $clog2(LATENCY + 1);
   localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {IDLE, WR_DATA, WAIT, RD_BURST, WR_DONE} state_t;

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic                we_q, we_d;
   logic [LINE_AW-1:0]  line_q, line_d;
   logic                wr_en;

   logic [WORD_W-1:0]   mem_q [MEM_WORDS];

   // Storage is preloaded once at time 0 and deliberately untouched by reset.
   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] = WORD_W'(i);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[{line_q, beat_q}] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         lat_q   <= '0;
         we_q    <= 1'b0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         we_q    <= we_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      beat_d          = beat_q;
      lat_d           = lat_q;
      we_d            = we_q;
      line_d          = line_q;
      wr_en           = 1'b0;
      mem_req_ready   = 1'b0;
      mem_wdata_ready = 1'b0;
      mem_rdata       = '0;
      mem_rdata_valid = 1'b0;
      mem_rdata_last  = 1'b0;
      mem_wr_done     = 1'b0;
      case (state_q)
         IDLE: begin
            mem_req_ready = 1'b1;
            if (mem_req_valid) begin
               we_d    = mem_req_we;
               line_d  = mem_req_line;
               beat_d  = '0;
               lat_d   = LAT_LOAD;
               state_d = mem_req_we ? WR_DATA : WAIT;
            end
         end
         WR_DATA: begin
            mem_wdata_ready = 1'b1;
            if (mem_wdata_valid) begin
               wr_en  = 1'b1;
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == BEAT_LAST) begin
                  lat_d   = LAT_LOAD;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (lat_q == '0) begin
               beat_d  = '0;
               state_d = we_q ? WR_DONE : RD_BURST;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         RD_BURST: begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = mem_q[{line_q, beat_q}];
            mem_rdata_last  = (beat_q == BEAT_LAST);
            if (mem_rdata_ready) begin
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == BEAT_LAST) state_d = IDLE;
            end
         end
         WR_DONE: begin
            mem_wr_done = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset is synchronous, so the state may still be busy during the first
      // reset cycle; mask everything visible so nothing leaks out while rst=1.
      if (rst) begin
         wr_en           = 1'b0;
         mem_req_ready   = 1'b0;
         mem_wdata_ready = 1'b0;
         mem_rdata       = '0;
         mem_rdata_valid = 1'b0;
         mem_rdata_last  = 1'b0;
         mem_wr_done     = 1'b0;
      end
   end

endmodule

// File: tb/tb_main_memory_backend.sv
module tb_main_memory_backend;

   localparam int LAT = 4;
   localparam int WPL = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [7:0]  mem_req_line;
   logic [31:0] mem_wdata;
   logic        mem_wdata_valid, mem_wdata_ready;
   logic [31:0] mem_rdata;
   logic        mem_rdata_valid, mem_rdata_last, mem_rdata_ready;
   logic        mem_wr_done;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_mem [1024];

   always #5 clk = ~clk;

   main_memory_backend dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_line(mem_req_line),
      .mem_wdata(mem_wdata), .mem_wdata_valid(mem_wdata_valid),
      .mem_wdata_ready(mem_wdata_ready),
      .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
      .mem_rdata_last(mem_rdata_last), .mem_rdata_ready(mem_rdata_ready),
      .mem_wr_done(mem_wr_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%h exp=%h @%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Present a request in the current cycle; returns in the first cycle after accept.
   task automatic send_req(input logic we, input logic [7:0] line);
      chk("req_ready_idle", {31'b0, mem_req_ready}, 32'd1);
      mem_req_valid = 1'b1;
      mem_req_we    = we;
      mem_req_line  = line;
      cyc();
      mem_req_valid = 1'b0;
   endtask

   // Latency wait plus full burst with rdata_ready=1, then check return to IDLE.
   task automatic read_tail(input int line);
      for (int i = 0; i < LAT; i++) begin
         chk("wait_valid", {31'b0, mem_rdata_valid}, 32'd0);
         chk("wait_rdata", mem_rdata, 32'd0);
         chk("wait_req_ready", {31'b0, mem_req_ready}, 32'd0);
         cyc();
      end
      for (int b = 0; b < WPL; b++) begin
         chk("beat_valid", {31'b0, mem_rdata_valid}, 32'd1);
         chk("beat_data", mem_rdata, exp_mem[line*WPL+b]);
         chk("beat_last", {31'b0, mem_rdata_last}, (b == WPL-1) ? 32'd1 : 32'd0);
         chk("burst_req_ready", {31'b0, mem_req_ready}, 32'd0);
         cyc();
      end
      chk("post_valid", {31'b0, mem_rdata_valid}, 32'd0);
      chk("post_req_ready", {31'b0, mem_req_ready}, 32'd1);
   endtask

   task automatic read_line(input int line);
      mem_rdata_ready = 1'b1;
      send_req(1'b0, 8'(line));
      read_tail(line);
   endtask

   task automatic write_line(input int line, input logic [31:0] base, input bit gaps);
      send_req(1'b1, 8'(line));
      for (int b = 0; b < WPL; b++) begin
         if (gaps) begin
            mem_wdata_valid = 1'b0;
            chk("gap_wdata_ready", {31'b0, mem_wdata_ready}, 32'd1);
            cyc();
         end
         mem_wdata       = base + 32'(b);
         mem_wdata_valid = 1'b1;
         chk("wdata_ready", {31'b0, mem_wdata_ready}, 32'd1);
         cyc();
         exp_mem[line*WPL+b] = base + 32'(b);
      end
      mem_wdata_valid = 1'b0;
      // Last beat accepted at edge E; wr_done expected in cycle E+LAT+1.
      for (int i = 0; i < LAT; i++) begin
         chk("wr_done_early", {31'b0, mem_wr_done}, 32'd0);
         chk("wr_wdata_ready", {31'b0, mem_wdata_ready}, 32'd0);
         cyc();
      end
      chk("wr_done_pulse", {31'b0, mem_wr_done}, 32'd1);
      cyc();
      chk("wr_done_once", {31'b0, mem_wr_done}, 32'd0);
      chk("wr_req_ready", {31'b0, mem_req_ready}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) exp_mem[i] = 32'(i);
      rst = 1'b1;
      mem_req_valid = 1'b0; mem_req_we = 1'b0; mem_req_line = '0;
      mem_wdata = '0; mem_wdata_valid = 1'b0; mem_rdata_ready = 1'b0;

      // 1: reset for 3 cycles, everything quiet, then read line 0
      repeat (3) begin
         cyc();
         chk("rst_req_ready", {31'b0, mem_req_ready}, 32'd0);
         chk("rst_rdata_valid", {31'b0, mem_rdata_valid}, 32'd0);
         chk("rst_wdata_ready", {31'b0, mem_wdata_ready}, 32'd0);
         chk("rst_wr_done", {31'b0, mem_wr_done}, 32'd0);
      end
      rst = 1'b0;
      cyc();
      read_line(0);

      // 2: write line 5, then read it back
      write_line(5, 32'hAAAA_0000, 1'b0);
      read_line(5);
      chk("t2_model_w3", exp_mem[23], 32'hAAAA_0003);

      // 3: read line 2 with a 3-cycle stall at beat 1
      mem_rdata_ready = 1'b1;
      send_req(1'b0, 8'd2);
      repeat (LAT) cyc();
      chk("t3_b0", mem_rdata, 32'd8);
      cyc();
      chk("t3_b1", mem_rdata, 32'd9);
      mem_rdata_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t3_hold_data", mem_rdata, 32'd9);
         chk("t3_hold_valid", {31'b0, mem_rdata_valid}, 32'd1);
         chk("t3_hold_last", {31'b0, mem_rdata_last}, 32'd0);
      end
      mem_rdata_ready = 1'b1;
      cyc();
      chk("t3_b2", mem_rdata, 32'd10);
      chk("t3_b2_last", {31'b0, mem_rdata_last}, 32'd0);
      cyc();
      chk("t3_b3", mem_rdata, 32'd11);
      chk("t3_b3_last", {31'b0, mem_rdata_last}, 32'd1);
      cyc();
      chk("t3_idle", {31'b0, mem_req_ready}, 32'd1);

      // 4: second request held during a read burst, accepted only after it
      send_req(1'b0, 8'd1);
      mem_req_valid = 1'b1;
      mem_req_we    = 1'b0;
      mem_req_line  = 8'd6;
      read_tail(1);
      cyc();
      mem_req_valid = 1'b0;
      read_tail(6);

      // 5: reset in the middle of a read of line 3
      send_req(1'b0, 8'd3);
      repeat (LAT) cyc();
      chk("t5_b0", mem_rdata, 32'd12);
      cyc();
      chk("t5_b1", mem_rdata, 32'd13);
      rst = 1'b1;
      cyc();
      chk("t5_rst_valid", {31'b0, mem_rdata_valid}, 32'd0);
      chk("t5_rst_ready", {31'b0, mem_req_ready}, 32'd0);
      rst = 1'b0;
      cyc();
      chk("t5_after_valid", {31'b0, mem_rdata_valid}, 32'd0);
      chk("t5_after_ready", {31'b0, mem_req_ready}, 32'd1);
      read_line(3);

      // 6: write top line with gaps, neighbours untouched
      write_line(255, 32'h5555_0000, 1'b1);
      read_line(255);
      read_line(254);
      read_line(0);
      chk("t6_model_1016", exp_mem[1016], 32'd1016);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
